// File: rtl/hamming_byte_sequencer.sv
// Sequencer between the UART receiver and a Hamming(7,4) decoder.
// Takes two codewords and issues one decode request for each. Packs the
// two decoded nibbles into a byte, with the low nibble first. Tracks
// corrected errors and raises sticky overrun/timeout flags.
//
// Output handshake: o_out_valid rises when a byte is ready. It stays high
// with o_byte_out/o_byte_corrected stable until a cycle where i_out_ready is
// also high; the byte counts as transferred on that clock edge and
// o_out_valid drops in the following cycle.
module hamming_byte_sequencer #(
  parameter int DEC_WAIT_MAX = 15,
  parameter int GAP_MAX      = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ena,
  input  logic       i_rx_valid,
  input  logic [6:0] i_rx_code,
  output logic       o_dec_start,
  output logic [6:0] o_dec_code,
  input  logic       i_dec_valid,
  input  logic [3:0] i_dec_data,
  input  logic [2:0] i_dec_syndrome,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_byte_out,
  output logic       o_byte_corrected,
  output logic [7:0] o_err_count,
  output logic       o_overrun,
  output logic       o_timeout,
  input  logic       i_clr_flags,
  output logic [1:0] o_state_out
);

  localparam int WAIT_W = $clog2(DEC_WAIT_MAX + 1);
  // Limits are compared one count early so the exit edge lands exactly on the limit.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DEC_WAIT_MAX - 1);
  localparam logic [15:0]       GAP_LAST  = 16'(GAP_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DEC     = 2'd1,
    S_WAIT_HI = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_take_rx;
  logic                w_lo_done;
  logic                w_hi_done;
  logic                w_set_timeout;
  logic                w_set_overrun;
  logic                w_err_inc;

  logic                r_nib_sel;
  logic [3:0]          r_lo_nib;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [15:0]         r_gap_cnt;
  logic                r_dec_start;
  logic [6:0]          r_dec_code;
  logic                r_out_valid;
  logic [7:0]          r_byte_out;
  logic                r_byte_corrected;
  logic [7:0]          r_err_count;
  logic                r_overrun;
  logic                r_timeout;

  // State register; everything freezes while i_ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (i_ena) begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    w_next        = r_state;
    w_take_rx     = 1'b0;
    w_lo_done     = 1'b0;
    w_hi_done     = 1'b0;
    w_set_timeout = 1'b0;
    w_set_overrun = 1'b0;
    w_err_inc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          w_take_rx = 1'b1;
          w_next    = S_DEC;
        end
      end
      S_DEC: begin
        w_set_overrun = i_rx_valid;
        if (i_dec_valid) begin
          w_err_inc = (i_dec_syndrome != 3'd0);
          if (!r_nib_sel) begin
            w_lo_done = 1'b1;
            w_next    = S_WAIT_HI;
          end else begin
            w_hi_done = 1'b1;
            w_next    = S_OUT;
          end
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_set_timeout = 1'b1;
          w_next        = S_IDLE;
        end
      end
      S_WAIT_HI: begin
        if (i_rx_valid) begin
          w_take_rx = 1'b1;
          w_next    = S_DEC;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_set_timeout = 1'b1;
          w_next        = S_IDLE;
        end
      end
      S_OUT: begin
        w_set_overrun = i_rx_valid;
        if (i_out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: codeword latch, timers, nibble assembly and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nib_sel        <= 1'b0;
      r_lo_nib         <= 4'd0;
      r_wait_cnt       <= '0;
      r_gap_cnt        <= 16'd0;
      r_dec_start      <= 1'b0;
      r_dec_code       <= 7'd0;
      r_out_valid      <= 1'b0;
      r_byte_out       <= 8'd0;
      r_byte_corrected <= 1'b0;
      r_err_count      <= 8'd0;
      r_overrun        <= 1'b0;
      r_timeout        <= 1'b0;
    end else if (i_ena) begin
      r_dec_start <= w_take_rx;
      r_out_valid <= (w_next == S_OUT);

      if (w_take_rx) begin
        r_dec_code <= i_rx_code;
        r_nib_sel  <= (r_state == S_WAIT_HI);
      end

      // A fresh byte starts clean; a correction on either nibble marks it.
      if (w_take_rx && (r_state == S_IDLE)) begin
        r_byte_corrected <= 1'b0;
      end else if (w_err_inc) begin
        r_byte_corrected <= 1'b1;
      end

      if (w_take_rx) begin
        r_wait_cnt <= '0;
      end else if ((r_state == S_DEC) && !i_dec_valid) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end

      if (w_lo_done) begin
        r_gap_cnt <= 16'd0;
      end else if (r_state == S_WAIT_HI) begin
        r_gap_cnt <= r_gap_cnt + 16'd1;
      end

      if (w_lo_done) begin
        r_lo_nib <= i_dec_data;
      end
      if (w_hi_done) begin
        r_byte_out <= {i_dec_data, r_lo_nib};
      end

      // Set events beat a simultaneous clear.
      if (i_clr_flags) begin
        r_err_count <= w_err_inc ? 8'd1 : 8'd0;
      end else if (w_err_inc && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end

      if (w_set_overrun) begin
        r_overrun <= 1'b1;
      end else if (i_clr_flags) begin
        r_overrun <= 1'b0;
      end

      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end else if (i_clr_flags) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign o_dec_start      = r_dec_start;
  assign o_dec_code       = r_dec_code;
  assign o_out_valid      = r_out_valid;
  assign o_byte_out       = r_byte_out;
  assign o_byte_corrected = r_byte_corrected;
  assign o_err_count      = r_err_count;
  assign o_overrun        = r_overrun;
  assign o_timeout        = r_timeout;
  assign o_state_out      = r_state;

endmodule
